multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the mips32 benchmark core. It sequences one shared memory port and the datapath through IDLE/FETCH/DECODE/EXEC/MEM/WB.
- It issues the per-state datapath enables (IR, PC, memory, register file, ALU source and op), handles the memory ready handshake with timeout, and counts retired instructions.
- It sits between the instruction register/memory interface and the datapath muxes.

Parameters:
- MEM_WAIT_MAX, 15: maximum consecutive cycles with mem_ready=0 in one memory access before a fault. 0 disables the timeout.
- CNT_W, 32: width of retired_count.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  start/continue request.
- instruction  in  32  IR contents; valid from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- alu_zero  in  1  ALU zero flag (beq compare).
- state  out  3  current state encoding.
- mem_req  out  1  memory access request.
- mem_we  out  1  write enable, qualified by mem_req.
- mem_addr_sel  out  1  0 = PC, 1 = ALU result.
- ir_write  out  1  load IR from memory data.
- pc_write  out  1  PC update enable.
- pc_src  out  2  00 = PC+4, 01 = branch target, 10 = jump target.
- reg_write  out  1  register file write.
- reg_dst  out  1  1 = rd, 0 = rt.
- mem_to_reg  out  1  write-back data from memory.
- alu_src  out  2  00 = rt, 01 = immediate, 10 = shamt, 11 = variable shift.
- alu_op  out  1  1 = use the funct field.
- retired  out  1  one-cycle pulse per completed instruction.
- retired_count  out  CNT_W  retired instruction count; wraps.
- halted  out  1  sticky; set by break or fault.
- fault  out  1  sticky; memory timeout.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, retired_count=0, wait counter=0, halted=0, fault=0. All other outputs are 0 because they decode from IDLE. Reset mid-access abandons the access.
- Outputs are combinational from the state register, instruction, alu_zero and mem_ready. Any output not named for a state is 0 in that state.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- IDLE: run=1 moves to FETCH; run is otherwise ignored here.
- FETCH: mem_req=1, mem_addr_sel=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=00, then DECODE.
  - Otherwise stay in FETCH.
- DECODE, by instruction[31:26]:
  - 0 with funct 13 (break): HALT, with retired=1.
  - 2 (j): pc_write=1, pc_src=10, retire.
  - 4 (beq), 8, 10, 12, 13, 14, 15 (I-type), 35 (lw), 43 (sw), and other funct values under opcode 0: EXEC.
  - Any other opcode: NOP, retire.
- EXEC:
  - R-type: alu_op=1. alu_src=10 if funct<4, 11 if funct<8, otherwise 00. Then WB.
  - I-type, lw, sw: alu_src=01. I-type goes to WB; lw and sw go to MEM.
  - beq: alu_src=00, pc_src=01, pc_write=alu_zero, retire.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for sw.
  - On mem_ready: sw retires; lw goes to WB.
- WB: reg_write=1, retire.
  - reg_dst=1 for R-type.
  - mem_to_reg=1 for lw.
- Retire (DECODE, EXEC, MEM or WB completion): retired=1 for one cycle, retired_count+1 (wraps at 2^CNT_W). Next state is FETCH if run=1, otherwise IDLE.
- Wait counter: cleared on entry to FETCH/MEM and on mem_ready; increments each FETCH/MEM cycle with mem_ready=0.
  - If the counter equals MEM_WAIT_MAX while mem_ready=0 (and MEM_WAIT_MAX>0), next state is HALT with fault=1.
  - mem_ready in that same cycle wins over the timeout.
- HALT: halted=1; no outputs other than the flags. Leaves only on reset; run is ignored.
- Zero-wait latency: j 2 cycles, beq 3, R-type/I-type/sw 4, lw 5. Each memory wait cycle adds 1.

Decomposition:
- Package mips32_pkg holds:
  - opcode constants (OP_RTYPE=0, OP_J=2, OP_BEQ=4, OP_ADDI=8, OP_SLTI=10, OP_ANDI=12, OP_ORI=13, OP_XORI=14, OP_LUI=15, OP_LW=35, OP_SW=43) and FUNCT_BREAK=13;
  - state encodings;
  - pc_src and alu_src encodings.
- One sub-module, instr_class: a combinational opcode/funct classifier with one-hot outputs is_rtype, is_shift_imm, is_shift_var, is_break, is_j, is_beq, is_itype, is_lw, is_sw, is_nop.

Test Plan:
- Reset, run=1, zero-wait memory, add (opcode 0, funct 32) -> states 1,2,3,5,1; reg_write=1 with reg_dst=1 in WB; retired pulses once; retired_count=1.
- lw with mem_ready delayed 3 cycles in FETCH and 2 in MEM -> total 5+5=10 cycles; mem_addr_sel=1 only in MEM; mem_to_reg=1 in WB; no fault.
- beq twice, alu_zero=1 then 0 -> pc_write=1/pc_src=01 on the first, pc_write=0 on the second; each takes 3 cycles; count +2.
- MEM_WAIT_MAX=4, mem_ready held 0 in FETCH -> HALT after the 5th FETCH cycle; fault=1, halted=1; run toggling has no effect.
- break (0x0000000D) -> HALT; halted=1, fault=0, retired_count incremented once; rst_n pulse returns to IDLE with all outputs 0.
- sw issued with run dropped to 0 before retirement -> mem_we=1 in MEM, retire, then IDLE. Also: rst_n asserted mid-MEM -> immediate IDLE, count=0.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared opcode, state and mux-select encodings for the mips32 multi-cycle core.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package mips32_pkg;

    localparam logic [5:0] OP_RTYPE    = 6'd0;
    localparam logic [5:0] OP_J        = 6'd2;
    localparam logic [5:0] OP_BEQ      = 6'd4;
    localparam logic [5:0] OP_ADDI     = 6'd8;
    localparam logic [5:0] OP_SLTI     = 6'd10;
    localparam logic [5:0] OP_ANDI     = 6'd12;
    localparam logic [5:0] OP_ORI      = 6'd13;
    localparam logic [5:0] OP_XORI     = 6'd14;
    localparam logic [5:0] OP_LUI      = 6'd15;
    localparam logic [5:0] OP_LW       = 6'd35;
    localparam logic [5:0] OP_SW       = 6'd43;
    localparam logic [5:0] FUNCT_BREAK = 6'd13;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_t;

    typedef enum logic [1:0] {
        ALU_RT    = 2'b00,
        ALU_IMM   = 2'b01,
        ALU_SHAMT = 2'b10,
        ALU_SHVAR = 2'b11
    } alu_src_t;

endpackage

// File: rtl/multicycle_sequencer_instr_class.sv
// Combinational opcode/funct classifier; exactly one class output is high.
// Latency: zero cycles, purely combinational.
// Backpressure: none; output follows the instruction input.
module instr_class
    import mips32_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       is_rtype,
    output logic       is_shift_imm,
    output logic       is_shift_var,
    output logic       is_break,
    output logic       is_j,
    output logic       is_beq,
    output logic       is_itype,
    output logic       is_lw,
    output logic       is_sw,
    output logic       is_nop
);

    logic op_r;

    assign op_r         = (opcode == OP_RTYPE);
    // Shift classes pick the ALU B source: funct 0-3 use shamt, 4-7 use rs.
    assign is_break     = op_r && (funct == FUNCT_BREAK);
    assign is_shift_imm = op_r && (funct < 6'd4);
    assign is_shift_var = op_r && (funct >= 6'd4) && (funct < 6'd8);
    assign is_rtype     = op_r && !is_break && !is_shift_imm && !is_shift_var;
    assign is_j         = (opcode == OP_J);
    assign is_beq       = (opcode == OP_BEQ);
    assign is_itype     = (opcode == OP_ADDI) || (opcode == OP_SLTI) || (opcode == OP_ANDI) ||
                          (opcode == OP_ORI)  || (opcode == OP_XORI) || (opcode == OP_LUI);
    assign is_lw        = (opcode == OP_LW);
    assign is_sw        = (opcode == OP_SW);
    assign is_nop       = !(op_r || is_j || is_beq || is_itype || is_lw || is_sw);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM sequencing one shared memory port and the datapath enables.
// Latency: j 2, beq 3, R/I/sw 4, lw 5 cycles, plus one per memory wait cycle.
// Backpressure: FETCH/MEM hold until mem_ready; a wait longer than MEM_WAIT_MAX halts with fault.
module multicycle_sequencer
    import mips32_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [31:0]      instruction,
    input  logic             mem_ready,
    input  logic             alu_zero,
    output logic [2:0]       state,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic [1:0]       alu_src,
    output logic             alu_op,
    output logic             retired,
    output logic [CNT_W-1:0] retired_count,
    output logic             halted,
    output logic             fault
);

    localparam int WAIT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT_MAX);

    state_t            st, st_nxt, retire_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  cnt_q;
    logic              halted_q, fault_q;
    logic              in_mem_phase, timeout;
    logic              is_rtype, is_shift_imm, is_shift_var, is_break, is_j;
    logic              is_beq, is_itype, is_lw, is_sw, is_nop;
    logic              unused_instr_bits;

    // Only opcode and funct steer the sequencer; the rest of the IR feeds the datapath.
    assign unused_instr_bits = ^instruction[25:6];

    instr_class u_class (
        .opcode       (instruction[31:26]),
        .funct        (instruction[5:0]),
        .is_rtype     (is_rtype),
        .is_shift_imm (is_shift_imm),
        .is_shift_var (is_shift_var),
        .is_break     (is_break),
        .is_j         (is_j),
        .is_beq       (is_beq),
        .is_itype     (is_itype),
        .is_lw        (is_lw),
        .is_sw        (is_sw),
        .is_nop       (is_nop)
    );

    assign in_mem_phase  = (st == ST_FETCH) || (st == ST_MEM);
    // A ready in the limit cycle completes the access instead of faulting.
    assign timeout       = in_mem_phase && !mem_ready && (MEM_WAIT_MAX > 0) && (wait_cnt == WAIT_LIMIT);
    assign retire_nxt    = run ? ST_FETCH : ST_IDLE;
    assign state         = st;
    assign retired_count = cnt_q;
    assign halted        = halted_q;
    assign fault         = fault_q;

    // Per-state datapath enables and next-state selection.
    always_comb begin
        st_nxt       = st;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_PLUS4;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        alu_src      = ALU_RT;
        alu_op       = 1'b0;
        retired      = 1'b0;
        case (st)
            ST_IDLE: begin
                if (run) st_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    st_nxt   = ST_DECODE;
                end else if (timeout) begin
                    st_nxt = ST_HALT;
                end
            end
            ST_DECODE: begin
                if (is_break) begin
                    retired = 1'b1;
                    st_nxt  = ST_HALT;
                end else if (is_j) begin
                    pc_write = 1'b1;
                    pc_src   = PC_JUMP;
                    retired  = 1'b1;
                    st_nxt   = retire_nxt;
                end else if (is_nop) begin
                    retired = 1'b1;
                    st_nxt  = retire_nxt;
                end else begin
                    st_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_rtype || is_shift_imm || is_shift_var) begin
                    alu_op  = 1'b1;
                    alu_src = is_shift_imm ? ALU_SHAMT : (is_shift_var ? ALU_SHVAR : ALU_RT);
                    st_nxt  = ST_WB;
                end else if (is_beq) begin
                    pc_src   = PC_BRANCH;
                    pc_write = alu_zero;
                    retired  = 1'b1;
                    st_nxt   = retire_nxt;
                end else begin
                    alu_src = ALU_IMM;
                    st_nxt  = (is_lw || is_sw) ? ST_MEM : ST_WB;
                end
            end
            ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = is_sw;
                if (mem_ready) begin
                    if (is_sw) begin
                        retired = 1'b1;
                        st_nxt  = retire_nxt;
                    end else begin
                        st_nxt = ST_WB;
                    end
                end else if (timeout) begin
                    st_nxt = ST_HALT;
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                reg_dst    = is_rtype || is_shift_imm || is_shift_var;
                mem_to_reg = is_lw;
                retired    = 1'b1;
                st_nxt     = retire_nxt;
            end
            ST_HALT: begin
                st_nxt = ST_HALT;
            end
            default: begin
                st_nxt = ST_IDLE;
            end
        endcase
    end

    // State, wait counter, retire counter and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= ST_IDLE;
            wait_cnt <= '0;
            cnt_q    <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            st       <= st_nxt;
            wait_cnt <= (in_mem_phase && !mem_ready && !timeout) ? wait_cnt + WAIT_W'(1) : '0;
            if (retired)            cnt_q    <= cnt_q + CNT_W'(1);
            if (st_nxt == ST_HALT)  halted_q <= 1'b1;
            if (timeout)            fault_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench: instruction-level trace model checked every cycle plus literal spot checks.
// Latency: expected traces encode the per-class cycle counts and memory wait cycles.
// Backpressure: mem_ready is driven from the stimulus trace, including timeout cases.
module tb_multicycle_sequencer;

    localparam int MAXW = 4;
    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                           S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;

    typedef struct packed {
        logic [2:0]  state;
        logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
        logic [1:0]  pc_src;
        logic        reg_write, reg_dst, mem_to_reg;
        logic [1:0]  alu_src;
        logic        alu_op, retired, halted, fault;
        logic [31:0] count;
    } obs_t;

    typedef struct packed {
        logic        run, mr, az;
        logic [31:0] ins;
        obs_t        e;
    } step_t;

    logic clk, rst_n, run, mem_ready, alu_zero;
    logic [31:0] instruction;
    logic [2:0]  state;
    logic mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write, reg_dst, mem_to_reg;
    logic [1:0]  pc_src, alu_src;
    logic alu_op, retired, halted, fault;
    logic [31:0] retired_count;

    obs_t  act, exp_now;
    logic  exp_vld;
    step_t q[$];
    int    n_vec, n_miss, step_no;
    logic [31:0] m_cnt;
    logic  m_halted, m_fault;

    multicycle_sequencer #(.MEM_WAIT_MAX(MAXW), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .instruction(instruction),
        .mem_ready(mem_ready), .alu_zero(alu_zero), .state(state),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src(alu_src), .alu_op(alu_op), .retired(retired),
        .retired_count(retired_count), .halted(halted), .fault(fault)
    );

    assign act = {state, mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
                  reg_write, reg_dst, mem_to_reg, alu_src, alu_op, retired, halted, fault,
                  retired_count};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare process: every modelled cycle, mid-way between edges.
    always @(negedge clk) begin
        #2;
        if (exp_vld) begin
            n_vec++;
            if (act !== exp_now) begin
                n_miss++;
                $display("FAIL step%0d: state got %0d want %0d, outputs got %h want %h",
                         step_no, act.state, exp_now.state, act, exp_now);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic obs_t base(input logic [2:0] st);
        obs_t e;
        e        = '0;
        e.state  = st;
        e.count  = m_cnt;
        e.halted = m_halted;
        e.fault  = m_fault;
        return e;
    endfunction

    task automatic push(input logic r, input logic mr, input logic az, input logic [31:0] ins,
                        input obs_t e);
        step_t s;
        s.run = r; s.mr = mr; s.az = az; s.ins = ins; s.e = e;
        q.push_back(s);
    endtask

    task automatic idle(input logic r);
        push(r, 1'b0, 1'b0, 32'h0, base(S_IDLE));
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) push(i[0], 1'b0, 1'b0, 32'h0, base(S_HALT));
    endtask

    // Expected trace for one instruction from its class, wait counts and run level.
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                             input logic az, input logic run_end, input bit abort_mem);
        logic [5:0] op, fn;
        bit rt, brk, jj, bq, it, lw, sw;
        obs_t e;
        op  = ins[31:26];
        fn  = ins[5:0];
        rt  = (op == 0) && (fn != 13);
        brk = (op == 0) && (fn == 13);
        jj  = (op == 2);
        bq  = (op == 4);
        it  = op inside {6'd8, 6'd10, 6'd12, 6'd13, 6'd14, 6'd15};
        lw  = (op == 35);
        sw  = (op == 43);
        for (int i = 0; i < fw; i++) begin
            e = base(S_FETCH); e.mem_req = 1'b1;
            push(1'b1, 1'b0, az, ins, e);
        end
        e = base(S_FETCH); e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        push(1'b1, 1'b1, az, ins, e);
        e = base(S_DECODE);
        if (brk || jj || !(rt || bq || it || lw || sw)) begin
            e.retired = 1'b1;
            if (jj) begin e.pc_write = 1'b1; e.pc_src = 2'b10; end
            push(run_end, 1'b0, az, ins, e);
            m_cnt++;
            if (brk) m_halted = 1'b1;
            return;
        end
        push(run_end, 1'b0, az, ins, e);
        e = base(S_EXEC);
        if (rt) begin
            e.alu_op  = 1'b1;
            e.alu_src = (fn < 4) ? 2'b10 : ((fn < 8) ? 2'b11 : 2'b00);
        end else if (bq) begin
            e.pc_src = 2'b01; e.pc_write = az; e.retired = 1'b1;
            push(run_end, 1'b0, az, ins, e);
            m_cnt++;
            return;
        end else begin
            e.alu_src = 2'b01;
        end
        push(run_end, 1'b0, az, ins, e);
        if (lw || sw) begin
            for (int i = 0; i < mw; i++) begin
                e = base(S_MEM); e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.mem_we = sw;
                push(run_end, 1'b0, az, ins, e);
                if (abort_mem) return;
            end
            e = base(S_MEM); e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.mem_we = sw;
            if (sw) begin
                e.retired = 1'b1;
                push(run_end, 1'b1, az, ins, e);
                m_cnt++;
                return;
            end
            push(run_end, 1'b1, az, ins, e);
        end
        e = base(S_WB); e.reg_write = 1'b1; e.reg_dst = rt; e.mem_to_reg = lw; e.retired = 1'b1;
        push(run_end, 1'b0, az, ins, e);
        m_cnt++;
    endtask

    // FETCH never answered: the limit cycle is the (MAXW+1)th, then HALT with fault.
    task automatic timeout_fetch();
        obs_t e;
        for (int i = 0; i <= MAXW; i++) begin
            e = base(S_FETCH); e.mem_req = 1'b1;
            push(1'b1, 1'b0, 1'b0, 32'h0, e);
        end
        m_halted = 1'b1;
        m_fault  = 1'b1;
    endtask

    task automatic drain();
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            @(negedge clk);
            run = s.run; mem_ready = s.mr; alu_zero = s.az; instruction = s.ins;
            exp_now = s.e;
            exp_vld = 1'b1;
            step_no++;
        end
        #3;
        exp_vld = 1'b0;
    endtask

    task automatic do_reset();
        run = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0; instruction = 32'h0;
        rst_n = 1'b0;
        m_cnt = 0; m_halted = 1'b0; m_fault = 1'b0;
        #1;
    endtask

    initial begin
        n_vec = 0; n_miss = 0; step_no = 0; exp_vld = 1'b0;
        do_reset();
        #20;
        check("reset state", {29'h0, state}, 32'd0);
        check("reset count", retired_count, 32'd0);
        check("reset outputs", {31'h0, mem_req | ir_write | pc_write | halted | fault | retired}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        idle(1'b0); idle(1'b1);
        run_instr(32'h0000_0020, 0, 0, 1'b0, 1'b1, 0);               // add
        drain();
        check("add wb state", {29'h0, state}, 32'd5);
        check("add wb reg_dst/reg_write", {30'h0, reg_write, reg_dst}, 32'd3);

        run_instr(32'h8C00_0000, 3, 2, 1'b0, 1'b1, 0);               // lw, waits
        drain();
        check("lw wb mem_to_reg", {31'h0, mem_to_reg}, 32'd1);
        check("lw count", retired_count, 32'd1);
        check("lw no fault", {31'h0, fault}, 32'd0);

        run_instr(32'h0000_0000, 0, 0, 1'b0, 1'b1, 0);               // sll
        run_instr(32'h0000_0006, 0, 0, 1'b0, 1'b1, 0);               // srlv
        run_instr(32'h2000_0000, 0, 0, 1'b0, 1'b1, 0);               // addi
        run_instr(32'h0800_0000, 0, 0, 1'b0, 1'b1, 0);               // j
        run_instr(32'h0C00_0000, 0, 0, 1'b0, 1'b1, 0);               // jal -> nop
        run_instr(32'h1000_0000, 0, 0, 1'b1, 1'b1, 0);               // beq taken
        run_instr(32'h1000_0000, 0, 0, 1'b0, 1'b1, 0);               // beq not taken
        drain();
        check("beq2 pc_write", {31'h0, pc_write}, 32'd0);
        check("beq2 count", retired_count, 32'd8);

        run_instr(32'h8C00_0000, MAXW, 0, 1'b0, 1'b1, 0);            // ready on limit cycle
        run_instr(32'hAC00_0000, 0, 1, 1'b0, 1'b0, 0);               // sw, run dropped
        idle(1'b0); idle(1'b1);
        run_instr(32'h0000_000D, 0, 0, 1'b0, 1'b1, 0);               // break
        halt_cycles(4);
        drain();
        check("break state", {29'h0, state}, 32'd6);
        check("break halted/fault", {30'h0, halted, fault}, 32'd2);
        check("break count", retired_count, 32'd12);

        do_reset();
        check("post-halt reset state", {29'h0, state}, 32'd0);
        check("post-halt reset flags", {30'h0, halted, mem_req}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        idle(1'b1);
        timeout_fetch();
        halt_cycles(4);
        drain();
        check("timeout halted/fault", {30'h0, halted, fault}, 32'd3);

        do_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1);
        run_instr(32'hAC00_0000, 0, 1, 1'b0, 1'b1, 1);               // stop inside MEM
        drain();
        check("mid-mem state", {29'h0, state}, 32'd4);
        check("mid-mem mem_we", {31'h0, mem_we}, 32'd1);
        do_reset();
        check("mid-mem reset state", {29'h0, state}, 32'd0);
        check("mid-mem reset mem_req", {31'h0, mem_req}, 32'd0);
        check("mid-mem reset count", retired_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
